// File: rtl/id_stage.sv
// Instruction-decode stage: 32-entry register file, MIPS-subset decode, beq/j resolution, ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle write-back to both read ports and the beq compare.
module id_stage #(
    parameter int DW    = 32,
    parameter int RF_AW = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DW-1:0]    i_next_pc,
    input  logic [31:0]      i_instr,
    input  logic             i_wb_we,
    input  logic [RF_AW-1:0] i_wb_addr,
    input  logic [DW-1:0]    i_wb_data,
    output logic             o_pc_src,
    output logic [DW-1:0]    o_branch_addr,
    output logic [DW-1:0]    o_ex_pc,
    output logic [DW-1:0]    o_rd_data1,
    output logic [DW-1:0]    o_rd_data2,
    output logic [DW-1:0]    o_imm,
    output logic [RF_AW-1:0] o_rt,
    output logic [RF_AW-1:0] o_rd,
    output logic [5:0]       o_funct,
    output logic             o_reg_dst,
    output logic             o_alu_src,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [1:0]       o_alu_op
);

    localparam int NREG = 2 ** RF_AW;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef struct packed {
        logic [DW-1:0]    pc;
        logic [DW-1:0]    rd1;
        logic [DW-1:0]    rd2;
        logic [DW-1:0]    imm;
        logic [RF_AW-1:0] rt;
        logic [RF_AW-1:0] rd;
        logic [5:0]       funct;
        logic             reg_dst;
        logic             alu_src;
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic [1:0]       alu_op;
    } idex_t;

    logic [DW-1:0]        rf_q [NREG];
    logic [DW-1:0]        rf_d [NREG];
    idex_t                idex_q;
    idex_t                idex_d;

    logic [5:0]           opcode;
    logic [RF_AW-1:0]     rs;
    logic [RF_AW-1:0]     rt;
    logic [DW-1:0]        rd1;
    logic [DW-1:0]        rd2;
    logic signed [DW-1:0] imm_sext;
    logic signed [DW-1:0] br_offset;
    logic [DW-1:0]        beq_target;
    logic [DW-1:0]        j_target;

    assign opcode     = i_instr[31:26];
    assign rs         = i_instr[21 +: RF_AW];
    assign rt         = i_instr[16 +: RF_AW];
    assign imm_sext   = $signed({{(DW-16){i_instr[15]}}, i_instr[15:0]});
    assign br_offset  = imm_sext <<< 2;
    assign beq_target = i_next_pc + $unsigned(br_offset);
    assign j_target   = {i_next_pc[DW-1:DW-4], i_instr[25:0], 2'b00};

    // Register $0 is hard-wired to zero; the write-back bypass never applies to it.
    always_comb begin
        rd1 = (rs == '0) ? '0 : rf_q[rs];
        rd2 = (rt == '0) ? '0 : rf_q[rt];
`ifdef ID_WB_BYPASS_EN
        if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rs)) rd1 = i_wb_data;
        if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rt)) rd2 = i_wb_data;
`endif
    end

    always_comb begin
        rf_d = rf_q;
        if (i_wb_we && (i_wb_addr != '0)) rf_d[i_wb_addr] = i_wb_data;
    end

    always_comb begin
        o_pc_src      = 1'b0;
        o_branch_addr = '0;
        if (i_rst_n) begin
            if (opcode == OP_J) begin
                o_pc_src      = 1'b1;
                o_branch_addr = j_target;
            end else if ((opcode == OP_BEQ) && (rd1 == rd2)) begin
                o_pc_src      = 1'b1;
                o_branch_addr = beq_target;
            end
        end
    end

    always_comb begin
        idex_d            = '0;
        idex_d.pc         = i_next_pc;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.imm        = $unsigned(imm_sext);
        idex_d.rt         = rt;
        idex_d.rd         = i_instr[11 +: RF_AW];
        idex_d.funct      = i_instr[5:0];
        // Unlisted opcodes fall through with every control bit cleared (NOP).
        case (opcode)
            OP_R: begin
                idex_d.reg_dst   = 1'b1;
                idex_d.reg_write = 1'b1;
                idex_d.alu_op    = 2'b10;
            end
            OP_LW: begin
                idex_d.alu_src    = 1'b1;
                idex_d.mem_to_reg = 1'b1;
                idex_d.reg_write  = 1'b1;
                idex_d.mem_read   = 1'b1;
            end
            OP_SW: begin
                idex_d.alu_src   = 1'b1;
                idex_d.mem_write = 1'b1;
            end
            OP_ADDI: begin
                idex_d.alu_src   = 1'b1;
                idex_d.reg_write = 1'b1;
            end
            OP_BEQ:  idex_d.alu_op = 2'b01;
            default: ;
        endcase
    end

    // ID/EX boundary; a reset edge also discards any write-back presented on it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idex_q <= '0;
            rf_q   <= '{default: '0};
        end else begin
            idex_q <= idex_d;
            rf_q   <= rf_d;
        end
    end

    assign o_ex_pc      = idex_q.pc;
    assign o_rd_data1   = idex_q.rd1;
    assign o_rd_data2   = idex_q.rd2;
    assign o_imm        = idex_q.imm;
    assign o_rt         = idex_q.rt;
    assign o_rd         = idex_q.rd;
    assign o_funct      = idex_q.funct;
    assign o_reg_dst    = idex_q.reg_dst;
    assign o_alu_src    = idex_q.alu_src;
    assign o_mem_to_reg = idex_q.mem_to_reg;
    assign o_reg_write  = idex_q.reg_write;
    assign o_mem_read   = idex_q.mem_read;
    assign o_mem_write  = idex_q.mem_write;
    assign o_alu_op     = idex_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reference register-file model plus an ID/EX expectation queue.
module tb_id_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_next_pc;
    logic [31:0] i_instr;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_pc_src;
    logic [31:0] o_branch_addr;
    logic [31:0] o_ex_pc;
    logic [31:0] o_rd_data1;
    logic [31:0] o_rd_data2;
    logic [31:0] o_imm;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [5:0]  o_funct;
    logic        o_reg_dst;
    logic        o_alu_src;
    logic        o_mem_to_reg;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [1:0]  o_alu_op;

    id_stage #(.DW(32), .RF_AW(5)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_next_pc    (i_next_pc),
        .i_instr      (i_instr),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_pc_src     (o_pc_src),
        .o_branch_addr(o_branch_addr),
        .o_ex_pc      (o_ex_pc),
        .o_rd_data1   (o_rd_data1),
        .o_rd_data2   (o_rd_data2),
        .o_imm        (o_imm),
        .o_rt         (o_rt),
        .o_rd         (o_rd),
        .o_funct      (o_funct),
        .o_reg_dst    (o_reg_dst),
        .o_alu_src    (o_alu_src),
        .o_mem_to_reg (o_mem_to_reg),
        .o_reg_write  (o_reg_write),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_alu_op     (o_alu_op)
    );

    always #5 i_clk = ~i_clk;

    // ctl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [7:0]  ctl;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mrf [32];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && (wa == a)) return wd;
`endif
        return mrf[a];
    endfunction

    function automatic logic [7:0] ctl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 8'b1001_0010;
            6'h23:   return 8'b0111_1000;
            6'h2B:   return 8'b0100_0100;
            6'h08:   return 8'b0101_0000;
            6'h04:   return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // One clock: drive, check the combinational branch outputs, then the registered ID/EX word.
    task automatic cycle(input logic rst_n, input logic [31:0] instr, input logic [31:0] pc,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        exp_t        g;
        logic [31:0] r1, r2, tgt, off;
        logic        src;
        i_rst_n = rst_n; i_instr = instr; i_next_pc = pc;
        i_wb_we = we; i_wb_addr = wa; i_wb_data = wd;
        #2;
        r1 = mread(instr[25:21], we, wa, wd);
        r2 = mread(instr[20:16], we, wa, wd);
        src = 1'b0; tgt = 32'd0;
        off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (rst_n && instr[31:26] == 6'h02) begin
            src = 1'b1; tgt = {pc[31:28], instr[25:0], 2'b00};
        end else if (rst_n && instr[31:26] == 6'h04 && r1 == r2) begin
            src = 1'b1; tgt = pc + off;
        end
        chk("pc_src", {31'd0, o_pc_src}, {31'd0, src});
        chk("branch_addr", o_branch_addr, tgt);
        e = '0;
        if (rst_n) begin
            e.pc = pc; e.rd1 = r1; e.rd2 = r2;
            e.imm = {{16{instr[15]}}, instr[15:0]};
            e.rt = instr[20:16]; e.rd = instr[15:11]; e.funct = instr[5:0];
            e.ctl = ctl_of(instr[31:26]);
        end
        exp_q.push_back(e);
        @(posedge i_clk);
        if (!rst_n) mrf = '{default: 32'd0};
        else if (we && wa != 5'd0) mrf[wa] = wd;
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            g = '{o_ex_pc, o_rd_data1, o_rd_data2, o_imm, o_rt, o_rd, o_funct,
                  {o_reg_dst, o_alu_src, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write, o_alu_op}};
            chk("ex_pc", g.pc, e.pc);
            chk("rd_data1", g.rd1, e.rd1);
            chk("rd_data2", g.rd2, e.rd2);
            chk("imm", g.imm, e.imm);
            chk("rt", {27'd0, g.rt}, {27'd0, e.rt});
            chk("rd", {27'd0, g.rd}, {27'd0, e.rd});
            chk("funct", {26'd0, g.funct}, {26'd0, e.funct});
            chk("ctl", {24'd0, g.ctl}, {24'd0, e.ctl});
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0000;

    initial begin
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02, 6'h3F};
        mrf = '{default: 32'd0};

        // Reset with random inputs, then sweep every register through both read ports.
        cycle(1'b0, $urandom, $urandom, 1'b1, 5'($urandom), $urandom);
        cycle(1'b0, $urandom, $urandom, 1'b1, 5'($urandom), $urandom);
        for (int i = 0; i < 16; i++)
            cycle(1'b1, {6'h3F, 5'(i), 5'(31 - i), 16'h0000}, 32'h0, 1'b0, 5'd0, 32'd0);

        // add $3,$5,$0 after writing $5
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cycle(1'b1, 32'h00A0_1820, 32'h40, 1'b0, 5'd0, 32'd0);

        // beq $1,$2 taken then not taken
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd1, 32'd7);
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd2, 32'd7);
        cycle(1'b1, 32'h1022_0004, 32'h100, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd2, 32'd8);
        cycle(1'b1, 32'h1022_0004, 32'h100, 1'b0, 5'd0, 32'd0);
        // backward beq with wrap: $6==$0 both zero, offset -1
        cycle(1'b1, 32'h10C0_FFFF, 32'h0000_0002, 1'b0, 5'd0, 32'd0);

        // j
        cycle(1'b1, 32'h0800_0040, 32'h0040_0004, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h0BFF_FFFF, 32'hA000_0000, 1'b0, 5'd0, 32'd0);

        // lw, sw, addi, then $0 write ignored
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd2, 32'h10);
        cycle(1'b1, 32'h8C44_FFFC, 32'h8, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'hAC44_0010, 32'hC, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h2044_7FFF, 32'h10, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd0, 32'h1234);
        cycle(1'b1, 32'h0000_0000, 32'h14, 1'b1, 5'd0, 32'h1234);
        cycle(1'b1, 32'h0000_0000, 32'h18, 1'b0, 5'd0, 32'd0);

        // Same-cycle write-back and read of $7 on both ports
        cycle(1'b1, 32'h00E7_0000, 32'h1C, 1'b1, 5'd7, 32'h55);
        cycle(1'b1, 32'h00E7_0000, 32'h20, 1'b0, 5'd0, 32'd0);

        // Random traffic over a small register window so hazards occur
        for (int i = 0; i < 40; i++)
            cycle(1'b1, {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 16'($urandom)},
                  $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);

        // Mid-run reset drops its write-back, then $9 must read 0
        cycle(1'b1, NOP, 32'h0, 1'b1, 5'd9, 32'hCAFE_F00D);
        cycle(1'b0, 32'h0800_0001, 32'h44, 1'b1, 5'd10, 32'h1111_2222);
        cycle(1'b1, 32'h0129_0000, 32'h48, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h0140_0000, 32'h4C, 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
